wave_gen_multi: RTL and testbench

//   Multi-channel waveform generator with runtime-programmable rate.

---
 rtl/wave_gen_pkg.sv | 15 +
 rtl/wave_gen_ch.sv | 85 ++++++++
 rtl/wave_gen_multi.sv | 88 ++++++++
 tb/tb_wave_gen_multi.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_gen_pkg.sv
// Shared types for the multi-channel wave generator.
// Mode encodings and direction constants.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    MODE_SAW_UP   = 2'd0,
    MODE_SAW_DN   = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_HOLD     = 2'd3
  } mode_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/wave_gen_ch.sv
// One waveform channel: level, direction and wrap pulse.
// A load always wins over a step on the same edge.
module wave_gen_ch
  import wave_gen_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic [1:0]       mode_i,
  input  logic             load_en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] level_o,
  output logic             dir_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] level_q, level_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    level_d = level_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (load_en_i) begin
      level_d = load_val_i;
    end else if (tick_i) begin
      case (mode_e'(mode_i))
        MODE_SAW_UP: begin
          dir_d   = DIR_UP;
          level_d = level_q + ONE;
          wrap_d  = (level_d == ZERO);
        end
        MODE_SAW_DN: begin
          dir_d   = DIR_DN;
          level_d = level_q - ONE;
          wrap_d  = (level_d == MAX);
        end
        MODE_TRIANGLE: begin
          // endpoints turn around without repeating
          if (dir_q == DIR_UP) begin
            if (level_q == MAX) begin
              level_d = level_q - ONE;
              dir_d   = DIR_DN;
            end else begin
              level_d = level_q + ONE;
            end
          end else begin
            if (level_q == ZERO) begin
              level_d = ONE;
              dir_d   = DIR_UP;
            end else begin
              level_d = level_q - ONE;
            end
          end
          wrap_d = (level_d == ZERO);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
      dir_q   <= DIR_UP;
      wrap_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  assign level_o = level_q;
  assign dir_o   = dir_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/wave_gen_multi.sv
// Multi-channel wave generator: shared rate divider, load decode, PWM.
// PWM stage built only with WAVE_GEN_MULTI_PWM_EN defined.
module wave_gen_multi
  import wave_gen_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_CH    = 3,
  parameter int DIV_WIDTH = 16,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [DIV_WIDTH-1:0]    div,
  input  logic                    load,
  input  logic [CH_W-1:0]         ch_sel,
  input  logic [WIDTH-1:0]        load_val,
  output logic [NUM_CH*WIDTH-1:0] level,
  output logic [NUM_CH-1:0]       dir,
  output logic [NUM_CH-1:0]       wrap,
  output logic [NUM_CH-1:0]       pwm_out
);

  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic                 tick;

  // >= so lowering div below the count ticks at once
  assign tick = enable && (div_cnt_q >= div);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (tick)
      div_cnt_d = '0;
    else if (enable)
      div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt_q <= '0;
    else
      div_cnt_q <= div_cnt_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic load_en;
    assign load_en = load && (ch_sel == CH_W'(i));

    wave_gen_ch #(.WIDTH(WIDTH)) u_ch (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .tick_i     (tick),
      .mode_i     (mode),
      .load_en_i  (load_en),
      .load_val_i (load_val),
      .level_o    (level[i*WIDTH +: WIDTH]),
      .dir_o      (dir[i]),
      .wrap_o     (wrap[i])
    );
  end

`ifdef WAVE_GEN_MULTI_PWM_EN
  logic [WIDTH-1:0]  pwm_cnt_q;
  logic [NUM_CH-1:0] pwm_q, pwm_d;

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      pwm_d[i] = (pwm_cnt_q < level[i*WIDTH +: WIDTH]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      pwm_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + WIDTH'(1);
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
`else
  assign pwm_out = '0;
`endif

endmodule

// File: tb/tb_wave_gen_multi.sv
// Directed-vector bench for wave_gen_multi, WIDTH=4, NUM_CH=3.
// PWM expectations follow WAVE_GEN_MULTI_PWM_EN.
module tb_wave_gen_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] div;
  logic        load;
  logic [1:0]  ch_sel;
  logic [3:0]  load_val;
  logic [11:0] level;
  logic [2:0]  dir;
  logic [2:0]  wrap;
  logic [2:0]  pwm_out;

  int nvec = 0;
  int nerr = 0;

  wave_gen_multi #(.WIDTH(4), .NUM_CH(3), .DIV_WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .mode     (mode),
    .div      (div),
    .load     (load),
    .ch_sel   (ch_sel),
    .load_val (load_val),
    .level    (level),
    .dir      (dir),
    .wrap     (wrap),
    .pwm_out  (pwm_out)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] lv3(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic [3:0] c);
    return {c, b, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [15:0] d);
    @(negedge clk);
    rst_n    = 1'b0;
    enable   = 1'b1;
    mode     = m;
    div      = d;
    load     = 1'b0;
    ch_sel   = 2'd0;
    load_val = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; mode = 2'd0; div = 16'd0;
    load = 1'b0; ch_sel = 2'd0; load_val = 4'd0;
    #12;
    nvec++;
    if (level !== 12'h000) begin
      nerr++; $display("FAIL reset_level got=%h exp=000", level);
    end
    nvec++;
    if (dir !== 3'b111) begin
      nerr++; $display("FAIL reset_dir got=%b exp=111", dir);
    end
    nvec++;
    if (wrap !== 3'b000) begin
      nerr++; $display("FAIL reset_wrap got=%b exp=000", wrap);
    end
    nvec++;
    if (pwm_out !== 3'b000) begin
      nerr++; $display("FAIL reset_pwm got=%b exp=000", pwm_out);
    end
  endtask

  task automatic test_saw_up();
    logic [3:0] e;
    logic [2:0] ew;
    do_reset(2'd0, 16'd0);
    for (int k = 1; k < 20; k++) begin
      step();
      e  = 4'(k % 16);
      ew = (k == 16) ? 3'b111 : 3'b000;
      nvec++;
      if (level !== lv3(e, e, e)) begin
        nerr++; $display("FAIL saw_up_level k=%0d got=%h exp=%h", k, level, lv3(e, e, e));
      end
      nvec++;
      if (wrap !== ew || dir !== 3'b111) begin
        nerr++; $display("FAIL saw_up_wrap k=%0d got=%b/%b exp=%b/111", k, wrap, dir, ew);
      end
    end
  endtask

  task automatic test_triangle();
    int n;
    logic [3:0] e;
    logic [2:0] ed, ew;
    do_reset(2'd2, 16'd2);
    for (int k = 1; k <= 93; k++) begin
      step();
      n  = k / 3;
      e  = (n <= 15) ? 4'(n) : (n <= 30) ? 4'(30 - n) : 4'(n - 30);
      ed = (n >= 16 && n <= 30) ? 3'b000 : 3'b111;
      ew = (k == 90) ? 3'b111 : 3'b000;
      nvec++;
      if (level !== lv3(e, e, e) || dir !== ed || wrap !== ew) begin
        nerr++;
        $display("FAIL triangle k=%0d got=%h/%b/%b exp=%h/%b/%b",
                 k, level, dir, wrap, lv3(e, e, e), ed, ew);
      end
    end
  endtask

  task automatic test_load();
    do_reset(2'd0, 16'd0);
    repeat (5) step();
    load = 1'b1; ch_sel = 2'd1; load_val = 4'd8;
    step();
    nvec++;
    if (level !== lv3(4'd6, 4'd8, 4'd6) || wrap !== 3'b000) begin
      nerr++; $display("FAIL load_ch1 got=%h/%b exp=%h/000", level, wrap, lv3(4'd6, 4'd8, 4'd6));
    end
    ch_sel = 2'd2; load_val = 4'd4;
    step();
    nvec++;
    if (level !== lv3(4'd7, 4'd9, 4'd4)) begin
      nerr++; $display("FAIL load_ch2 got=%h exp=%h", level, lv3(4'd7, 4'd9, 4'd4));
    end
    ch_sel = 2'd3; load_val = 4'd12;
    step();
    nvec++;
    if (level !== lv3(4'd8, 4'd10, 4'd5)) begin
      nerr++; $display("FAIL load_sel3 got=%h exp=%h", level, lv3(4'd8, 4'd10, 4'd5));
    end
    enable = 1'b0; ch_sel = 2'd0; load_val = 4'd15;
    step();
    nvec++;
    if (level !== lv3(4'd15, 4'd10, 4'd5)) begin
      nerr++; $display("FAIL load_disabled got=%h exp=%h", level, lv3(4'd15, 4'd10, 4'd5));
    end
    enable = 1'b1; load = 1'b0;
    step();
    nvec++;
    if (level !== lv3(4'd0, 4'd11, 4'd6) || wrap !== 3'b001) begin
      nerr++; $display("FAIL load_resume got=%h/%b exp=%h/001", level, wrap, lv3(4'd0, 4'd11, 4'd6));
    end
    load = 1'b1; ch_sel = 2'd1; load_val = 4'd15;
    step();
    load = 1'b0;
    step();
    nvec++;
    if (level !== lv3(4'd2, 4'd0, 4'd8) || wrap !== 3'b010) begin
      nerr++; $display("FAIL load_then_wrap got=%h/%b exp=%h/010", level, wrap, lv3(4'd2, 4'd0, 4'd8));
    end
  endtask

  task automatic test_freeze();
    do_reset(2'd1, 16'd2);
    repeat (3) step();
    nvec++;
    if (level !== 12'hfff || wrap !== 3'b111 || dir !== 3'b000) begin
      nerr++; $display("FAIL saw_dn_first got=%h/%b/%b exp=fff/111/000", level, wrap, dir);
    end
    step();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      nvec++;
      if (level !== 12'hfff || wrap !== 3'b000 || dir !== 3'b000) begin
        nerr++; $display("FAIL freeze k=%0d got=%h/%b/%b exp=fff/000/000", k, level, wrap, dir);
      end
    end
    enable = 1'b1;
    step();
    nvec++;
    if (level !== 12'hfff) begin
      nerr++; $display("FAIL resume_hold got=%h exp=fff", level);
    end
    step();
    nvec++;
    if (level !== 12'heee) begin
      nerr++; $display("FAIL resume_tick got=%h exp=eee", level);
    end
  endtask

  task automatic test_div_lower();
    do_reset(2'd0, 16'd10);
    repeat (5) step();
    nvec++;
    if (level !== 12'h000) begin
      nerr++; $display("FAIL div_wait got=%h exp=000", level);
    end
    div = 16'd2;
    step();
    nvec++;
    if (level !== 12'h111) begin
      nerr++; $display("FAIL div_lower got=%h exp=111", level);
    end
    step();
    step();
    nvec++;
    if (level !== 12'h111) begin
      nerr++; $display("FAIL div_restart got=%h exp=111", level);
    end
    step();
    nvec++;
    if (level !== 12'h222) begin
      nerr++; $display("FAIL div_next got=%h exp=222", level);
    end
  endtask

  task automatic test_async_reset();
    do_reset(2'd1, 16'd0);
    repeat (7) step();
    nvec++;
    if (level !== 12'h999 || dir !== 3'b000) begin
      nerr++; $display("FAIL pre_reset got=%h/%b exp=999/000", level, dir);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (level !== 12'h000 || dir !== 3'b111 || wrap !== 3'b000) begin
      nerr++; $display("FAIL async_reset got=%h/%b/%b exp=000/111/000", level, dir, wrap);
    end
  endtask

  task automatic test_pwm();
    int cnt [3];
    int ex  [3];
`ifdef WAVE_GEN_MULTI_PWM_EN
    ex[0] = 0; ex[1] = 5; ex[2] = 15;
`else
    ex[0] = 0; ex[1] = 0; ex[2] = 0;
`endif
    do_reset(2'd3, 16'd0);
    load = 1'b1; ch_sel = 2'd0; load_val = 4'd0;
    step();
    ch_sel = 2'd1; load_val = 4'd5;
    step();
    ch_sel = 2'd2; load_val = 4'd15;
    step();
    load = 1'b0;
    step();
    step();
    nvec++;
    if (level !== lv3(4'd0, 4'd5, 4'd15)) begin
      nerr++; $display("FAIL pwm_levels got=%h exp=%h", level, lv3(4'd0, 4'd5, 4'd15));
    end
    for (int c = 0; c < 3; c++) cnt[c] = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      for (int c = 0; c < 3; c++) cnt[c] += int'(pwm_out[c]);
    end
    for (int c = 0; c < 3; c++) begin
      nvec++;
      if (cnt[c] !== ex[c]) begin
        nerr++; $display("FAIL pwm_duty ch=%0d got=%0d exp=%0d", c, cnt[c], ex[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_saw_up();
    test_triangle();
    test_load();
    test_freeze();
    test_div_lower();
    test_async_reset();
    test_pwm();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
